if_fetch_queue: RTL and testbench

Next-generation instruction fetch stage with a decoupled, parametrised prefetch queue.
- Issues word-aligned fetches to instruction memory over a valid/ready request channel and accepts in-order responses with variable latency.
- Buffers fetched instructions in a FIFO_DEPTH-entry queue, so decode stalls no longer need a one-entry re-buffer.
- Handles trap and branch redirects by flushing the queue and discarding in-flight responses.
- Sits between the imem port and the IF/ID pipeline register, driving `if_id_t`.

---
 rtl/if_fetch_queue_pkg.sv | 23 ++
 rtl/if_fetch_queue_if.sv | 28 ++
 rtl/if_fetch_queue_fifo.sv | 67 ++++++
 rtl/if_fetch_queue.sv | 150 +++++++++++++++
 tb/tb_if_fetch_queue.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/if_fetch_queue_pkg.sv
// Shared types and defaults for the instruction fetch stage and its prefetch queue.
package if_fetch_queue_pkg;

  localparam int unsigned FQ_DEPTH_DEFAULT       = 4;
  localparam int unsigned FQ_OUTSTANDING_DEFAULT = 2;

  // One buffered fetch: the word address and the instruction returned for it.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
  } fq_entry_t;

  // IF/ID pipeline register payload.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc_plus_4;
    logic [31:0] insn;
    logic        valid;
    logic        stall;
    logic        flush;
  } if_id_t;

endpackage

// File: rtl/if_fetch_queue_if.sv
// Instruction-memory port: valid/ready request channel plus in-order response channel.
interface if_fetch_queue_if;

  logic        imem_req_valid_o;
  logic        imem_req_ready_i;
  logic [31:0] imem_addr_o;
  logic        imem_rsp_valid_i;
  logic [31:0] imem_rdata_i;

  // Fetch stage side.
  modport master (
    output imem_req_valid_o,
    output imem_addr_o,
    input  imem_req_ready_i,
    input  imem_rsp_valid_i,
    input  imem_rdata_i
  );

  // Instruction memory side.
  modport slave (
    input  imem_req_valid_o,
    input  imem_addr_o,
    output imem_req_ready_i,
    output imem_rsp_valid_i,
    output imem_rdata_i
  );

endinterface

// File: rtl/if_fetch_queue_fifo.sv
// Generic synchronous FIFO with synchronous clear; used for the instruction
// queue and for the pending-request PC queue.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clr_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign empty_o   = (r_count == '0);
  assign full_o    = (r_count == CW'(DEPTH));
  assign count_o   = r_count;
  assign rdata_o   = r_mem[r_rptr];
  assign w_do_pop  = pop_i && !empty_o;
  // A pop frees the slot, so push alongside pop is accepted even when full.
  assign w_do_push = push_i && (!full_o || w_do_pop);

  // Pointer and occupancy bookkeeping; clear discards any same-cycle push/pop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (clr_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= ptr_inc(r_wptr);
      if (w_do_pop)  r_rptr <= ptr_inc(r_rptr);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage write; contents are don't-care until the pointers cover them.
  always_ff @(posedge clk_i) begin
    if (w_do_push) r_mem[r_wptr] <= wdata_i;
  end

endmodule

// File: rtl/if_fetch_queue.sv
// Decoupled instruction fetch stage: issues word fetches, buffers in-order
// responses in a prefetch queue and flushes on trap/branch redirect.
module if_fetch_queue
  import if_fetch_queue_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH      = FQ_DEPTH_DEFAULT,
  parameter int unsigned MAX_OUTSTANDING = FQ_OUTSTANDING_DEFAULT
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  if_fetch_queue_if.master            imem,
  input  logic                        ex_is_pc_redirect_i,
  input  logic [31:0]                 ex_pc_target_i,
  input  logic                        wb_trap_valid_i,
  input  logic [31:0]                 trap_handler_addr_i,
  input  logic                        if_id_stall_i,
  input  logic                        if_id_flush_i,
  output if_id_t                      if_pipeline_d,
  output logic [$clog2(FIFO_DEPTH):0] fq_count_o
);

  localparam int unsigned QCW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned OCW = $clog2(MAX_OUTSTANDING) + 1;

  logic [31:0]    r_fetch_pc;
  logic [31:0]    w_fetch_pc_nxt;
  logic [31:0]    w_fetch_addr;
  logic [OCW-1:0] r_drop_cnt;
  logic [OCW-1:0] w_drop_cnt_nxt;
  logic [OCW-1:0] w_outstanding;
  logic [OCW-1:0] w_outstanding_nxt;
  logic           w_redirect;
  logic [31:0]    w_redirect_pc;
  logic [31:0]    w_live;
  logic           w_req_valid;
  logic           w_req_fire;
  logic           w_rsp_fire;
  logic [31:0]    w_pend_pc;
  logic           w_pend_full;
  logic           w_pend_empty;
  fq_entry_t      w_q_wdata;
  fq_entry_t      w_q_head;
  logic           w_q_push;
  logic           w_q_pop;
  logic           w_q_full;
  logic           w_q_empty;
  logic [QCW-1:0] w_q_count;
  logic           w_out_valid;

  // Trap outranks an EX redirect.
  assign w_redirect    = wb_trap_valid_i || ex_is_pc_redirect_i;
  assign w_redirect_pc = (wb_trap_valid_i ? trap_handler_addr_i : ex_pc_target_i) & ~32'h3;

  // Outstanding count is the pending-PC FIFO occupancy. Requests are gated so
  // every response that will be kept already owns a queue slot.
  assign w_fetch_addr = {r_fetch_pc[31:2], 2'b00};
  assign w_live       = 32'(w_outstanding) - 32'(r_drop_cnt) + 32'(w_q_count);
  assign w_req_valid  = rst_ni && !w_pend_full && (w_live < FIFO_DEPTH);
  assign w_req_fire   = w_req_valid && imem.imem_req_ready_i;
  assign w_rsp_fire   = imem.imem_rsp_valid_i && !w_pend_empty;

  assign imem.imem_req_valid_o = w_req_valid;
  assign imem.imem_addr_o      = w_fetch_addr;

  assign w_q_wdata   = '{pc: w_pend_pc, insn: imem.imem_rdata_i};
  assign w_q_push    = w_rsp_fire && (r_drop_cnt == '0);
  assign w_out_valid = !w_q_empty && !w_redirect;
  assign w_q_pop     = w_out_valid && !if_id_stall_i;
  assign fq_count_o  = w_q_count;

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (MAX_OUTSTANDING)
  ) u_pend_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr_i   (1'b0),
    .push_i  (w_req_fire),
    .pop_i   (w_rsp_fire),
    .wdata_i (w_fetch_addr),
    .rdata_o (w_pend_pc),
    .full_o  (w_pend_full),
    .empty_o (w_pend_empty),
    .count_o (w_outstanding)
  );

  sync_fifo #(
    .WIDTH ($bits(fq_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_insn_q (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr_i   (w_redirect),
    .push_i  (w_q_push),
    .pop_i   (w_q_pop),
    .wdata_i (w_q_wdata),
    .rdata_o (w_q_head),
    .full_o  (w_q_full),
    .empty_o (w_q_empty),
    .count_o (w_q_count)
  );

  // Next fetch PC, outstanding and drop counts after this cycle's events.
  always_comb begin
    w_outstanding_nxt = w_outstanding;
    if (w_req_fire) w_outstanding_nxt = w_outstanding_nxt + OCW'(1);
    if (w_rsp_fire) w_outstanding_nxt = w_outstanding_nxt - OCW'(1);

    w_fetch_pc_nxt = r_fetch_pc;
    if (w_req_fire) w_fetch_pc_nxt = w_fetch_addr + 32'd4;
    if (w_redirect) w_fetch_pc_nxt = w_redirect_pc;

    w_drop_cnt_nxt = r_drop_cnt;
    if (w_rsp_fire && (r_drop_cnt != '0)) w_drop_cnt_nxt = r_drop_cnt - OCW'(1);
    // Every request still unanswered after this cycle belongs to the old path.
    if (w_redirect) w_drop_cnt_nxt = w_outstanding_nxt;
  end

  // Fetch PC and stale-response drop counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_fetch_pc <= {RESET_PC[31:2], 2'b00};
      r_drop_cnt <= '0;
    end else begin
      r_fetch_pc <= w_fetch_pc_nxt;
      r_drop_cnt <= w_drop_cnt_nxt;
    end
  end

  // IF/ID payload from the queue head; data fields held at zero when not valid.
  always_comb begin
    if_pipeline_d       = '0;
    if_pipeline_d.valid = w_out_valid;
    if_pipeline_d.stall = if_id_stall_i;
    if_pipeline_d.flush = if_id_flush_i;
    if (w_out_valid) begin
      if_pipeline_d.pc        = w_q_head.pc;
      if_pipeline_d.pc_plus_4 = w_q_head.pc + 32'd4;
      if_pipeline_d.insn      = w_q_head.insn;
    end
  end

  a_rsp_needs_req: assert property (@(posedge clk_i) disable iff (!rst_ni)
    imem.imem_rsp_valid_i |-> !w_pend_empty);

  a_no_push_on_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (w_q_push && w_q_full) |-> w_q_pop);

endmodule

// File: tb/tb_if_fetch_queue.sv
module tb_if_fetch_queue;
  import if_fetch_queue_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_redir, trap, stall, flush;
  logic [31:0] ex_tgt, trap_addr;
  if_id_t      pipe;
  logic [2:0]  fq_count;

  if_fetch_queue_if imem_bus ();

  if_fetch_queue #(
    .RESET_PC        (RST_PC),
    .FIFO_DEPTH      (4),
    .MAX_OUTSTANDING (2)
  ) dut (
    .clk_i               (clk),
    .rst_ni              (rst_n),
    .imem                (imem_bus.master),
    .ex_is_pc_redirect_i (ex_redir),
    .ex_pc_target_i      (ex_tgt),
    .wb_trap_valid_i     (trap),
    .trap_handler_addr_i (trap_addr),
    .if_id_stall_i       (stall),
    .if_id_flush_i       (flush),
    .if_pipeline_d       (pipe),
    .fq_count_o          (fq_count)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [31:0] insn; } exp_t;
  typedef struct { logic [31:0] data; int unsigned due; bit live; } pend_t;

  exp_t        sb[$];
  pend_t       pend[$];
  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int          model_count = 0;
  logic [31:0] exp_fetch = RST_PC;
  int unsigned lat_lo = 1, lat_hi = 1, rdy_pct = 100;
  int unsigned cyc = 0, last_due = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a ^ 32'hC0DE_0000) + {a[7:0], a[31:8]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Waits (bounded) for the next delivered instruction and checks its pc.
  task automatic wait_valid(input string name, input logic [31:0] exp_pc);
    bit ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (pipe.valid && !stall) ok = 1;
    end
    if (ok) check(name, pipe.pc, exp_pc);
    else begin
      vectors++;
      miscompares++;
      $display("FAIL %s: no valid instruction within 40 cycles, expected pc %h", name, exp_pc);
    end
  endtask

  // Instruction memory model with in-order, variable-latency responses.
  // Also issues expectations: every request accepted outside a redirect cycle
  // is a live instruction on the current path.
  initial begin
    bit          redir;
    int unsigned due;
    imem_bus.imem_req_ready_i = 1'b0;
    imem_bus.imem_rsp_valid_i = 1'b0;
    imem_bus.imem_rdata_i     = '0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (rst_n && pend.size() > 0 && pend[0].due <= cyc) begin
        imem_bus.imem_rsp_valid_i = 1'b1;
        imem_bus.imem_rdata_i     = pend[0].data;
      end else begin
        imem_bus.imem_rsp_valid_i = 1'b0;
        imem_bus.imem_rdata_i     = $urandom;
      end
      imem_bus.imem_req_ready_i = ($urandom_range(99) < rdy_pct);
      @(negedge clk);
      #1;
      if (!rst_n) begin
        pend.delete();
        sb.delete();
        model_count = 0;
        exp_fetch   = RST_PC;
        last_due    = cyc;
      end else begin
        redir = trap || ex_redir;
        if (imem_bus.imem_rsp_valid_i) begin
          if (pend[0].live && !redir) model_count++;
          void'(pend.pop_front());
        end
        if (imem_bus.imem_req_valid_o && imem_bus.imem_req_ready_i) begin
          due = cyc + $urandom_range(lat_hi, lat_lo);
          if (due <= last_due) due = last_due + 1;
          last_due = due;
          pend.push_back('{data: mem_word(imem_bus.imem_addr_o), due: due, live: !redir});
          if (!redir) sb.push_back('{pc: exp_fetch, insn: mem_word(exp_fetch)});
        end
        if (redir) begin
          foreach (pend[i]) pend[i].live = 1'b0;
          sb.delete();
          model_count = 0;
          exp_fetch = (trap ? trap_addr : ex_tgt) & ~32'h3;
        end else if (imem_bus.imem_req_valid_o && imem_bus.imem_req_ready_i) begin
          exp_fetch = exp_fetch + 32'd4;
        end
      end
    end
  end

  // Monitor: compares every delivered instruction against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("fq_count", 32'(fq_count), 32'(model_count));
        check("stall_pass", 32'(pipe.stall), 32'(stall));
        check("flush_pass", 32'(pipe.flush), 32'(flush));
        if (trap || ex_redir) check("valid_in_redirect", 32'(pipe.valid), 32'd0);
        if (pipe.valid && !stall) begin
          if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_insn: got pc %h, expected no instruction", pipe.pc);
          end else begin
            e = sb.pop_front();
            model_count--;
            check("insn_pc", pipe.pc, e.pc);
            check("insn_data", pipe.insn, e.insn);
            check("pc_plus_4", pipe.pc_plus_4, e.pc + 32'd4);
          end
        end
        if (imem_bus.imem_req_valid_o) check("fetch_addr", imem_bus.imem_addr_o, exp_fetch);
      end
    end
  end

  // Directed scenarios followed by a randomized phase.
  initial begin
    bit ok;
    int unsigned r;
    ex_redir = 0; trap = 0; stall = 0; flush = 0;
    ex_tgt = '0; trap_addr = '0;

    repeat (3) tick();
    @(negedge clk);
    check("rst_req_valid", 32'(imem_bus.imem_req_valid_o), 32'd0);
    check("rst_valid", 32'(pipe.valid), 32'd0);
    check("rst_pc", pipe.pc, 32'd0);
    check("rst_insn", pipe.insn, 32'd0);
    check("rst_fq_count", 32'(fq_count), 32'd0);

    // Zero-wait memory: first instruction two cycles after release.
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("first_req_valid", 32'(imem_bus.imem_req_valid_o), 32'd1);
    check("lat_c0_valid", 32'(pipe.valid), 32'd0);
    @(negedge clk);
    check("lat_c1_valid", 32'(pipe.valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stream_valid", 32'(pipe.valid), 32'd1);
      check("stream_pc", pipe.pc, RST_PC + 32'(4 * i));
      check("stream_fq_le1", 32'(fq_count <= 3'd1), 32'd1);
    end

    // Downstream stall: queue saturates and requests stop.
    tick();
    stall = 1;
    repeat (10) tick();
    @(negedge clk);
    check("stall_fq_full", 32'(fq_count), 32'd4);
    check("stall_req_off", 32'(imem_bus.imem_req_valid_o), 32'd0);
    tick();
    stall = 0;
    repeat (12) tick();

    // Latency 3 with two requests in flight, then EX redirect to an unaligned target.
    lat_lo = 3; lat_hi = 3;
    ok = 0;
    for (int i = 0; i < 30 && !ok; i++) begin
      tick();
      if (pend.size() == 2) ok = 1;
    end
    check("two_outstanding", 32'(ok), 32'd1);
    ex_redir = 1; ex_tgt = 32'h0000_2002;
    tick();
    ex_redir = 0;
    @(negedge clk);
    check("q_empty_after_redir", 32'(fq_count), 32'd0);
    wait_valid("redir_first_pc", 32'h0000_2000);
    wait_valid("redir_second_pc", 32'h0000_2004);

    // Trap and EX redirect together under zero-wait (handshake + response in that cycle).
    lat_lo = 1; lat_hi = 1;
    repeat (6) tick();
    trap = 1; trap_addr = 32'h0000_0080;
    ex_redir = 1; ex_tgt = 32'h0000_0400;
    tick();
    trap = 0; ex_redir = 0;
    wait_valid("trap_prio_pc", 32'h0000_0080);
    wait_valid("trap_next_pc", 32'h0000_0084);

    // Address wrap at the top of the address space.
    tick();
    ex_redir = 1; ex_tgt = 32'hFFFF_FFF8;
    tick();
    ex_redir = 0;
    wait_valid("wrap_pc0", 32'hFFFF_FFF8);
    wait_valid("wrap_pc1", 32'hFFFF_FFFC);
    wait_valid("wrap_pc2", 32'h0000_0000);

    // Asynchronous reset mid-stream.
    repeat (2) tick();
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_req_valid", 32'(imem_bus.imem_req_valid_o), 32'd0);
    check("async_rst_valid", 32'(pipe.valid), 32'd0);
    check("async_rst_fq_count", 32'(fq_count), 32'd0);
    check("async_rst_pc", pipe.pc, 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    wait_valid("post_rst_pc0", RST_PC);
    wait_valid("post_rst_pc1", RST_PC + 32'd4);

    // Randomized traffic.
    rdy_pct = 75; lat_lo = 1; lat_hi = 4;
    for (int i = 0; i < 1500; i++) begin
      tick();
      r        = $urandom_range(99);
      stall    = ($urandom_range(3) == 0);
      flush    = ($urandom_range(7) == 0);
      trap     = (r < 2);
      ex_redir = (r >= 2 && r < 5);
      trap_addr = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
      ex_tgt    = $urandom;
    end

    // Drain: stop accepting requests and let everything in flight come out.
    tick();
    stall = 0; flush = 0; trap = 0; ex_redir = 0; rdy_pct = 0;
    ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      tick();
      if (sb.size() == 0 && pend.size() == 0) ok = 1;
    end
    check("drain_complete", 32'(ok), 32'd1);
    @(negedge clk);
    check("drain_fq_count", 32'(fq_count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
